ocm_port_master: RTL
====================

# ocm_port_master

Initiator for one slave port of the dual-port on-chip memory (7-bit word address, 64-bit data, byteenable, chipselect/clken/write, fixed read latency). Accepts block read/write commands over a valid/ready command channel and turns them into sequential single-word memory accesses. Write data streams in; read data streams out with backpressure. The design instantiates one per memory port that needs a streaming engine, typically on s2 while software uses s1.

## Interface
Parameters:
- ADDR_W, 7, memory word-address width; memory depth 2^ADDR_W
- DATA_W, 64, data width; byteenable width DATA_W/8
- READ_LATENCY, 1, memory readdata latency in cycles (legal: 1 or 2)

Ports:
- clk_clk  in  1  sole clock
- reset_reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write block, 0 = read block
- cmd_addr  in  ADDR_W  start word address
- cmd_len  in  ADDR_W+1  word count, 1..2^ADDR_W
- cmd_be  in  DATA_W/8  byteenable applied to every write beat
- wr_valid / wr_ready  in / out  1  write-data handshake
- wr_data  in  DATA_W  write beat
- rd_valid / rd_ready  out / in  1  read-data handshake
- rd_data  out  DATA_W  read beat
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, command complete
- err  out  1  one-cycle pulse, command rejected
- mem_address  out  ADDR_W, mem_chipselect / mem_clken / mem_write  out  1, mem_writedata  out  DATA_W, mem_byteenable  out  DATA_W/8, mem_readdata  in  DATA_W  slave-port connection

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: cmd_ready=1. When cmd_valid, capture cmd fields. If len==0 or (range check fails, see Configuration), pulse err next cycle and stay in IDLE. Otherwise go to WRITE or READ. Set addr_ptr=cmd_addr and remaining=cmd_len.
- WRITE: wr_ready=1. Each wr_valid&wr_ready cycle drives mem_chipselect=1, mem_write=1, mem_address=addr_ptr, mem_writedata=wr_data and mem_byteenable=cmd_be combinationally in that cycle. It then increments addr_ptr mod 2^ADDR_W and decrements remaining. After the last beat, pulse done next cycle and return to IDLE.
- READ: issue a read (chipselect=1, write=0, byteenable all ones) when remaining>0 and out_count+inflight<4. Data is captured READ_LATENCY cycles later into a 4-entry output FIFO. When remaining reaches 0, go to DRAIN.
- DRAIN: stay until inflight==0 and the FIFO is empty. done pulses in the cycle after the final rd handshake, then return to IDLE.
- rd_valid = FIFO not empty, and rd_data = FIFO head. Simultaneous push and pop leave the count unchanged. The FIFO can never overflow by construction.
- mem_clken=1 whenever reset_reset=0. mem_chipselect and mem_write are 0 whenever no access is issued.
- Reset in any state aborts immediately: in-flight reads are discarded, the FIFO is cleared, and no done or err is generated.

## Timing
- Reset values: cmd_ready=0, wr_ready=0, rd_valid=0, busy=0, done=0, err=0, mem_chipselect=0, mem_write=0, mem_address=0, mem_writedata=0, mem_byteenable=0, mem_clken=0. cmd_ready rises in the first cycle after reset deasserts.
- Command accept to first memory access: 1 cycle.
- Writes: 1 beat/cycle while wr_valid stays high. A block of N beats takes N cycles, and done fires in cycle N+1 after the first beat.
- Reads: 1 beat/cycle sustained with rd_ready held high. First rd_valid arrives READ_LATENCY+1 cycles after the first issue, counting the FIFO register.
- err and done never assert in the same cycle. busy=1 from the cycle after accept until the done cycle inclusive.

## Configuration
- OCM_PORT_MASTER_WRAP_EN defined: a block with cmd_addr+cmd_len > 2^ADDR_W is accepted, and its address wraps from 2^ADDR_W-1 to 0.
- Not defined: such a command is rejected with an err pulse and no memory access. len==0 is rejected in both builds.

## Test plan
- Write addr=0x10, len=4, be=0xFF, data 0xA0..0xA3 back-to-back -> mem_write high for 4 consecutive cycles, addresses 0x10..0x13, done pulse 1 cycle after the last beat.
- Read back addr=0x10, len=4, rd_ready=1 -> rd_data 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, done pulse after the 4th handshake.
- Read len=8 with rd_ready toggled 1-of-3 cycles -> no data lost or duplicated, at most 4 reads outstanding, order preserved.
- Write addr=0x7E, len=4 -> with WRAP_EN: addresses 0x7E, 0x7F, 0x00, 0x01 and done. Without WRAP_EN: err pulse, zero mem_chipselect cycles.
- cmd_len=0 -> err pulse 1 cycle after accept, busy stays 0.
- reset_reset asserted on the 2nd beat of a len=8 read -> all outputs return to reset values the next cycle, no done, and the next command runs normally.

Source files
------------

// File: rtl/ocm_port_master_if.sv
// Command, write-data and read-data streams of ocm_port_master.
// The block itself connects through the slave modport; a driver uses master.
interface ocm_port_master_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 64
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [ADDR_W:0]       cmd_len;
    logic [DATA_W/8-1:0]   cmd_be;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_W-1:0]     wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_W-1:0]     rd_data;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_be, wr_valid, wr_data, rd_ready,
        output cmd_ready, wr_ready, rd_valid, rd_data
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_be, wr_valid, wr_data, rd_ready,
        input  cmd_ready, wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/ocm_port_master.sv
// Streaming block read/write engine for one on-chip-memory slave port.
// Define OCM_PORT_MASTER_WRAP_EN to accept blocks that wrap past the top address.
module ocm_port_master #(
    parameter int ADDR_W       = 7,
    parameter int DATA_W       = 64,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    ocm_port_master_if.slave    st,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_clken,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic [DATA_W/8-1:0] mem_byteenable,
    input  logic [DATA_W-1:0]   mem_readdata
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_ptr;
    logic [ADDR_W:0]     remaining;
    logic [BE_W-1:0]     be_q;
    logic                err_q;
    logic [READ_LATENCY:1] vld_pipe;
    logic [2:0]          inflight;
    logic [DATA_W-1:0]   fifo [4];
    logic [1:0]          wr_ptr, rd_ptr;
    logic [2:0]          fifo_cnt;
    logic                accept, reject, range_bad;
    logic                wr_beat, rd_issue, push, pop;

`ifdef OCM_PORT_MASTER_WRAP_EN
    assign range_bad = 1'b0;
`else
    logic [ADDR_W+1:0] end_addr;
    assign end_addr  = {2'b00, st.cmd_addr} + {1'b0, st.cmd_len};
    // end_addr > 2^ADDR_W
    assign range_bad = end_addr[ADDR_W+1] | (end_addr[ADDR_W] & (|end_addr[ADDR_W-1:0]));
`endif

    always_comb begin
        inflight = '0;
        for (int i = 1; i <= READ_LATENCY; i++)
            inflight = inflight + {2'b00, vld_pipe[i]};
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) state <= IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        st.cmd_ready = 1'b0;
        st.wr_ready  = 1'b0;
        accept       = 1'b0;
        reject       = 1'b0;
        wr_beat      = 1'b0;
        rd_issue     = 1'b0;
        done         = 1'b0;
        if (!reset_reset) begin
            case (state)
                IDLE: begin
                    st.cmd_ready = 1'b1;
                    if (st.cmd_valid) begin
                        if (st.cmd_len == '0 || range_bad) begin
                            reject = 1'b1;
                        end else begin
                            accept    = 1'b1;
                            state_nxt = st.cmd_write ? WRITE : READ;
                        end
                    end
                end
                WRITE: begin
                    // remaining==0 here is the done cycle after the last beat
                    if (remaining == '0) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        st.wr_ready = 1'b1;
                        wr_beat     = st.wr_valid;
                    end
                end
                READ: begin
                    // credit: never more than 4 words between issue and pop
                    rd_issue = (remaining != '0) && ((fifo_cnt + inflight) < 3'd4);
                    if (rd_issue && remaining == 1) state_nxt = DRAIN;
                end
                DRAIN: begin
                    if (inflight == '0 && fifo_cnt == '0) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy           = (state != IDLE) && !reset_reset;
    assign err            = err_q && !reset_reset;
    assign mem_clken      = !reset_reset;
    assign mem_chipselect = wr_beat | rd_issue;
    assign mem_write      = wr_beat;
    assign mem_address    = (wr_beat | rd_issue) ? addr_ptr : '0;
    assign mem_writedata  = wr_beat ? st.wr_data : '0;
    assign mem_byteenable = wr_beat ? be_q : (rd_issue ? '1 : '0);

    assign push       = vld_pipe[READ_LATENCY];
    assign st.rd_valid = (fifo_cnt != '0) && !reset_reset;
    assign st.rd_data  = fifo[rd_ptr];
    assign pop        = st.rd_valid && st.rd_ready;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            addr_ptr  <= '0;
            remaining <= '0;
            be_q      <= '0;
            err_q     <= 1'b0;
            vld_pipe  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
        end else begin
            err_q <= reject;
            if (accept) begin
                addr_ptr  <= st.cmd_addr;
                remaining <= st.cmd_len;
                be_q      <= st.cmd_be;
            end else if (wr_beat || rd_issue) begin
                addr_ptr  <= addr_ptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            vld_pipe[1] <= rd_issue;
            for (int i = 2; i <= READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (push) fifo[wr_ptr] <= mem_readdata;
    end
endmodule
